// File: rtl/easy_fifo_sync_stat_if.sv
// easy_fifo_sync_stat_if
// Groups the write side, read side and status/error signals of the
// easy_fifo_sync_stat FIFO into one bundle.
//   master : the producer/consumer logic using the FIFO
//   slave  : the FIFO itself
interface easy_fifo_sync_stat_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16
);

  // Write side
  logic [DWIDTH-1:0]        wr_data;
  logic                     wr_en;
  logic                     wr_full;
  logic                     wr_afull;

  // Read side
  logic                     rd_en;
  logic [DWIDTH-1:0]        rd_data;
  logic                     rd_valid;
  logic                     rd_empty;
  logic                     rd_aempty;

  // Fill level and sticky error reporting
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;
  logic                     clr_err;

  modport master (
    output wr_data,
    output wr_en,
    output rd_en,
    output clr_err,
    input  wr_full,
    input  wr_afull,
    input  rd_data,
    input  rd_valid,
    input  rd_empty,
    input  rd_aempty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    input  rd_en,
    input  clr_err,
    output wr_full,
    output wr_afull,
    output rd_data,
    output rd_valid,
    output rd_empty,
    output rd_aempty,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/easy_fifo_sync_stat.sv
// easy_fifo_sync_stat
// Single-clock FIFO with occupancy count, almost-full / almost-empty
// thresholds and two read modes:
//   FWFT = 0 : registered read, rd_data/rd_valid one cycle after rd_en
//   FWFT = 1 : first-word-fall-through, head word always on rd_data
// Optional feature macro: EASY_FIFO_ERR_FLAG_EN
//   defined   -> sticky overflow/underflow flags, cleared by clr_err
//   undefined -> overflow/underflow held at 0, clr_err ignored
// Every status flag is decoded from the registered count only, so the
// only input-to-output path is the FWFT head-word read from the array.
module easy_fifo_sync_stat #(
  parameter int DWIDTH        = 32,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  easy_fifo_sync_stat_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_INC = ADDR_W'(1);

  // Storage array; contents are never reset, stale words are simply
  // unreachable once the pointers and count are cleared.
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  // Flags come straight from the registered occupancy.
  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  // A write into a full FIFO and a read from an empty one are refused;
  // because full and empty are exclusive, a simultaneous request on a
  // full FIFO still reads and on an empty FIFO still writes.
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  // Next pointers and occupancy from the accepted operations.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (wr_acc) begin
      wr_ptr_next = wr_ptr_reg + PTR_INC;
    end
    if (rd_acc) begin
      rd_ptr_next = rd_ptr_reg + PTR_INC;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + ONE_C;
      2'b01:   count_next = count_reg - ONE_C;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Array write port: store the accepted word at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  assign bus.count     = count_reg;
  assign bus.wr_full   = full;
  assign bus.wr_afull  = (count_reg >= AFULL_C);
  assign bus.rd_empty  = empty;
  assign bus.rd_aempty = (count_reg <= AEMPTY_C);

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally from the array, so a word
      // written on one edge is readable right after that edge.
      assign bus.rd_data  = mem[rd_ptr_reg];
      assign bus.rd_valid = !empty;
    end else begin : g_std
      logic [DWIDTH-1:0] rd_data_reg;
      logic              rd_valid_reg;

      // Registered read: capture the head word on an accepted read,
      // otherwise hold the last word; rd_valid marks the update cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) begin
            rd_data_reg <= mem[rd_ptr_reg];
          end
        end
      end

      assign bus.rd_data  = rd_data_reg;
      assign bus.rd_valid = rd_valid_reg;
    end
  endgenerate

`ifdef EASY_FIFO_ERR_FLAG_EN
  logic overflow_reg;
  logic overflow_next;
  logic underflow_reg;
  logic underflow_next;

  // Sticky error flags: a new error in the same cycle as clr_err wins,
  // so the event is never lost.
  always_comb begin
    overflow_next  = (overflow_reg  && !bus.clr_err) || (bus.wr_en && full);
    underflow_next = (underflow_reg && !bus.clr_err) || (bus.rd_en && empty);
  end

  // Error flag registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
`else
  // Error reporting compiled out: the ports stay so the FIFO drops into
  // either build unchanged, and clr_err is deliberately left unused.
  logic clr_err_unused;
  assign clr_err_unused = bus.clr_err;

  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_easy_fifo_sync_stat.sv
// tb_easy_fifo_sync_stat
// Two FIFO instances share clock and reset: u_std (registered read) and
// u_fw (first-word-fall-through). A fixed vector table covers the first
// cycles after reset; later phases use a queue scoreboard and a small
// occupancy model to derive every expected value.
module tb_easy_fifo_sync_stat;

  localparam int DW = 8;
  localparam int DP = 16;

`ifdef EASY_FIFO_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  easy_fifo_sync_stat_if #(.DWIDTH(DW), .DEPTH(DP)) std_if ();
  easy_fifo_sync_stat_if #(.DWIDTH(DW), .DEPTH(DP)) fw_if ();

  easy_fifo_sync_stat #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0)) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (std_if)
  );

  easy_fifo_sync_stat #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fw_if)
  );

  int total = 0;
  int bad   = 0;

  // Model state for the registered-read instance
  logic [DW-1:0] sb_q[$];
  int            m_cnt;
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_data;
  int            valid_pulses;

  // Model state for the FWFT instance
  logic [DW-1:0] fq[$];

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          rd;
    logic          clr;
    int            cnt;
    logic          empty;
    logic          aempty;
    logic          valid;
    logic [DW-1:0] data;
    logic          unf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of the registered-read FIFO with scoreboard update and checks.
  task automatic std_cycle(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    bit wr_ok;
    bit rd_ok;
    std_if.wr_en   = wr;
    std_if.wr_data = d;
    std_if.rd_en   = rd;
    std_if.clr_err = clr;
    wr_ok = wr && (m_cnt < DP);
    rd_ok = rd && (m_cnt > 0);
    if (ERR_EN) begin
      m_ovf = (m_ovf && !clr) || (wr && (m_cnt == DP));
      m_unf = (m_unf && !clr) || (rd && (m_cnt == 0));
    end
    if (rd_ok) m_data = sb_q.pop_front();
    if (wr_ok) sb_q.push_back(d);
    m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    @(posedge clk);
    #1;
    std_if.wr_en   = 1'b0;
    std_if.rd_en   = 1'b0;
    std_if.clr_err = 1'b0;
    $display("std wr=%b d=%h rd=%b clr=%b -> cnt=%0d valid=%b data=%h ovf=%b unf=%b",
             wr, d, rd, clr, std_if.count, std_if.rd_valid, std_if.rd_data,
             std_if.overflow, std_if.underflow);
    check("count",     32'(std_if.count),     32'(m_cnt));
    check("rd_empty",  32'(std_if.rd_empty),  32'(m_cnt == 0));
    check("wr_full",   32'(std_if.wr_full),   32'(m_cnt == DP));
    check("wr_afull",  32'(std_if.wr_afull),  32'(m_cnt >= DP - 2));
    check("rd_aempty", 32'(std_if.rd_aempty), 32'(m_cnt <= 2));
    check("rd_valid",  32'(std_if.rd_valid),  32'(rd_ok));
    check("rd_data",   32'(std_if.rd_data),   32'(m_data));
    check("overflow",  32'(std_if.overflow),  32'(m_ovf));
    check("underflow", 32'(std_if.underflow), 32'(m_unf));
    if (std_if.rd_valid) valid_pulses++;
  endtask

  // One clock of the FWFT FIFO; the head of fq is the word expected on rd_data.
  task automatic fw_cycle(input logic wr, input logic [DW-1:0] d, input logic rd);
    bit wr_ok;
    bit rd_ok;
    fw_if.wr_en   = wr;
    fw_if.wr_data = d;
    fw_if.rd_en   = rd;
    wr_ok = wr && (fq.size() < DP);
    rd_ok = rd && (fq.size() > 0);
    if (rd_ok) void'(fq.pop_front());
    if (wr_ok) fq.push_back(d);
    @(posedge clk);
    #1;
    fw_if.wr_en = 1'b0;
    fw_if.rd_en = 1'b0;
    $display("fwft wr=%b d=%h rd=%b -> cnt=%0d empty=%b valid=%b data=%h",
             wr, d, rd, fw_if.count, fw_if.rd_empty, fw_if.rd_valid, fw_if.rd_data);
    check("fw_count",    32'(fw_if.count),    32'(fq.size()));
    check("fw_rd_empty", 32'(fw_if.rd_empty), 32'(fq.size() == 0));
    check("fw_rd_valid", 32'(fw_if.rd_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) check("fw_rd_data", 32'(fw_if.rd_data), 32'(fq[0]));
  endtask

  initial begin
    std_if.wr_en = 1'b0; std_if.wr_data = '0; std_if.rd_en = 1'b0; std_if.clr_err = 1'b0;
    fw_if.wr_en  = 1'b0; fw_if.wr_data  = '0; fw_if.rd_en  = 1'b0; fw_if.clr_err  = 1'b0;

    // Hand-derived expectations for the first cycles (AEMPTY_THRESH = 2)
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[4] = '{1'b1, 8'h44, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0};

    // Reset, release, idle values
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_count",     32'(std_if.count),     32'd0);
    check("rst_rd_empty",  32'(std_if.rd_empty),  32'd1);
    check("rst_rd_aempty", 32'(std_if.rd_aempty), 32'd1);
    check("rst_wr_full",   32'(std_if.wr_full),   32'd0);
    check("rst_wr_afull",  32'(std_if.wr_afull),  32'd0);
    check("rst_rd_data",   32'(std_if.rd_data),   32'd0);
    check("rst_rd_valid",  32'(std_if.rd_valid),  32'd0);
    check("rst_overflow",  32'(std_if.overflow),  32'd0);
    check("rst_underflow", 32'(std_if.underflow), 32'd0);
    check("rst_fw_empty",  32'(fw_if.rd_empty),   32'd1);
    check("rst_fw_valid",  32'(fw_if.rd_valid),   32'd0);

    // Table-driven first cycles
    for (int i = 0; i < 10; i++) begin
      std_if.wr_en   = vecs[i].wr;
      std_if.wr_data = vecs[i].d;
      std_if.rd_en   = vecs[i].rd;
      std_if.clr_err = vecs[i].clr;
      @(posedge clk);
      #1;
      std_if.wr_en = 1'b0; std_if.rd_en = 1'b0; std_if.clr_err = 1'b0;
      $display("vec %0d wr=%b d=%h rd=%b clr=%b -> cnt=%0d valid=%b data=%h unf=%b",
               i, vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr,
               std_if.count, std_if.rd_valid, std_if.rd_data, std_if.underflow);
      check("vec_count",     32'(std_if.count),     32'(vecs[i].cnt));
      check("vec_rd_empty",  32'(std_if.rd_empty),  32'(vecs[i].empty));
      check("vec_rd_aempty", 32'(std_if.rd_aempty), 32'(vecs[i].aempty));
      check("vec_rd_valid",  32'(std_if.rd_valid),  32'(vecs[i].valid));
      check("vec_rd_data",   32'(std_if.rd_data),   32'(vecs[i].data));
      check("vec_underflow", 32'(std_if.underflow), 32'(vecs[i].unf & ERR_EN));
    end

    // Scoreboard model picks up from the state the table left behind
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_data = 8'h44; valid_pulses = 0;
    sb_q.delete();

    // Mid-fill asynchronous reset at count 5
    for (int i = 0; i < 5; i++) std_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_count",    32'(std_if.count),     32'd0);
    check("arst_rd_empty", 32'(std_if.rd_empty),  32'd1);
    check("arst_aempty",   32'(std_if.rd_aempty), 32'd1);
    check("arst_rd_data",  32'(std_if.rd_data),   32'd0);
    check("arst_rd_valid", 32'(std_if.rd_valid),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_data = '0;
    sb_q.delete();

    // Fill 0x00..0x0F, then a refused 17th write
    for (int i = 0; i < DP; i++) std_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    std_cycle(1'b1, 8'hEE, 1'b0, 1'b0);

    // Full with read+write: head word out, new word dropped; then drain
    valid_pulses = 0;
    std_cycle(1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < DP - 1; i++) std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("valid_pulses", 32'(valid_pulses), 32'(DP));
    std_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty with read+write: write only
    std_cycle(1'b1, 8'hC3, 1'b1, 1'b0);
    std_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Hold at count 8 under simultaneous traffic across pointer wrap
    for (int i = 0; i < 8; i++) std_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) std_cycle(1'b1, 8'(8'h90 + i), 1'b1, 1'b0);

    // Clear sticky flags, drain, then error coinciding with clr_err
    std_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    std_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    std_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT: single word falls through, pop empties on the next edge
    fq.delete();
    fw_cycle(1'b1, 8'hA5, 1'b0);
    check("fw_a5_data", 32'(fw_if.rd_data), 32'h0000_00A5);
    fw_cycle(1'b0, 8'h00, 1'b1);
    check("fw_pop_empty", 32'(fw_if.rd_empty), 32'd1);

    // FWFT: burst in, mixed traffic, burst out
    for (int i = 0; i < 4; i++) fw_cycle(1'b1, 8'(8'h31 * (i + 1)), 1'b0);
    for (int i = 0; i < 6; i++) fw_cycle(1'b1, 8'(8'hC0 + i), 1'b1);
    for (int i = 0; i < 5; i++) fw_cycle(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/easy_fifo_sync_stat.md
# easy_fifo_sync_stat

Synchronous single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds and a selectable read mode: standard (registered read, one-cycle latency) or first-word-fall-through. It is the next generation of the easy_fifo synchronous FIFO, and sits between producer and consumer logic that need back-pressure headroom and fill-level visibility.

## Interface
- DWIDTH, 32, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-2, wr_afull asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 2, rd_aempty asserts when count ≤ this value (0..DEPTH-1)
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_data  input  DWIDTH  write data
- wr_en  input  1  write request
- wr_full  output  1  count == DEPTH
- wr_afull  output  1  count ≥ AFULL_THRESH
- rd_en  input  1  read request (standard) / pop (FWFT)
- rd_data  output  DWIDTH  read data
- rd_valid  output  1  standard mode: rd_data updated this cycle; FWFT: equals !rd_empty
- rd_empty  output  1  count == 0
- rd_aempty  output  1  count ≤ AEMPTY_THRESH
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty
- clr_err  input  1  clears overflow/underflow

## Operation
- Storage: DEPTH×DWIDTH register array; write pointer, read pointer, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- Write accepted iff wr_en && !wr_full; data stored at write pointer, pointer increments.
- Read accepted iff rd_en && !rd_empty; read pointer increments.
- count: +1 write-only accepted, −1 read-only accepted, unchanged if both or neither.
- Full + wr_en + rd_en: write refused, read accepted, count → DEPTH-1.
- Empty + wr_en + rd_en: read refused, write accepted, count → 1.
- All status flags are combinational functions of the registered count only; no input-to-output combinational path except FWFT rd_data (from array/read pointer).
- Standard mode: on accepted read, rd_data ← mem[rd_ptr] registered, rd_valid pulses 1 for one cycle; otherwise rd_data holds, rd_valid = 0.
- FWFT mode: rd_data = mem[rd_ptr] continuously; valid whenever !rd_empty; rd_en acts as pop/acknowledge.
- Reset mid-operation: all contents discarded immediately; array contents not reset but unreachable.

## Timing
- Reset values: count 0, rd_empty 1, wr_full 0, wr_afull 0 (1 if AFULL_THRESH==0 is illegal, so 0), rd_aempty 1, rd_data 0, rd_valid 0, overflow 0, underflow 0, pointers 0.
- Write-to-visible latency: flags/count update on the edge accepting the write; FWFT data readable in the following cycle (min write-to-read latency 1 cycle).
- Standard read latency: rd_data/rd_valid valid 1 cycle after the accepting edge.
- Back-to-back reads/writes at full rate supported; throughput 1 word/cycle each side.

## Configuration
- Macro EASY_FIFO_ERR_FLAG_EN.
- Defined: overflow sets on any cycle with wr_en && wr_full; underflow on rd_en && rd_empty; both sticky until clr_err=1 at a clock edge; if clr_err and a new error occur same cycle, flag stays/sets to 1.
- Undefined: overflow and underflow tied to 0, clr_err ignored; ports remain present. FIFO data behaviour identical either way.

## Test plan
- Reset then idle: count 0, rd_empty 1, rd_aempty 1, wr_full 0, rd_data 0; deassert rst_n mid-fill (count 5) → all outputs return to reset values asynchronously.
- DEPTH=16, write 0x00..0x0F consecutively → wr_afull asserts when count reaches 14, wr_full at 16; 17th wr_en ignored, overflow=1 (macro on) or 0 (macro off).
- Drain full FIFO, FWFT=0 → rd_data 0x00..0x0F each 1 cycle after rd_en, rd_valid pulses 16 times; extra rd_en sets underflow, rd_data holds 0x0F.
- FWFT=1, single write 0xA5 to empty → next cycle rd_empty 0, rd_data 0xA5; rd_en → rd_empty 1 following cycle.
- Full FIFO with wr_en+rd_en same cycle → count 15, head word out, new word dropped; empty FIFO with both → count 1, no read.
- Continuous simultaneous read/write for 40 cycles at count 8 → count stays 8, data order preserved across pointer wrap-around; clr_err pulse clears sticky flags.
